// File: rtl/register_file_stage.sv
// Register file stage of the multicycle MIPS datapath: 32-entry architectural
// register array, the A/B operand latches and the immediate extender.
module register_file_stage #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] SP_INIT = WIDTH'(32'h7FFF_EFFC),
  parameter logic [WIDTH-1:0] GP_INIT = WIDTH'(32'h1000_8000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      Instr,
  input  logic             RegWrite,
  input  logic             RegDst,
  input  logic             MemtoReg,
  input  logic             Ori,
  input  logic [WIDTH-1:0] ALUOut,
  input  logic [WIDTH-1:0] MemData,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ExtImm,
  input  logic [4:0]       DbgAddr,
  output logic [WIDTH-1:0] DbgData
);

  logic [4:0]       rs, rt, rd, wa;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd1, rd2, dbg_rd;
  logic [WIDTH-1:0] regs_q [32];
  logic [WIDTH-1:0] a_q, b_q;

  assign rs = Instr[25:21];
  assign rt = Instr[20:16];
  assign rd = Instr[15:11];

  // Write-back address and data selection
  always_comb begin
    wa = RegDst ? rd : rt;
    wd = MemtoReg ? MemData : ALUOut;
  end

  // Register array; entry 0 is held at zero and never written, so it folds away
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == 28) ? GP_INIT : (i == 29) ? SP_INIT : '0;
      end
    end else if (RegWrite && (wa != 5'd0)) begin
      regs_q[wa] <= wd;
    end
  end

  // Combinational read ports, address 0 forced to zero
  always_comb begin
    rd1    = '0;
    rd2    = '0;
    dbg_rd = '0;
    if (rs != 5'd0)      rd1    = regs_q[rs];
    if (rt != 5'd0)      rd2    = regs_q[rt];
    if (DbgAddr != 5'd0) dbg_rd = regs_q[DbgAddr];
  end

  // Operand latches load the pre-write array value every edge (no bypass)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= rd1;
      b_q <= rd2;
    end
  end

  // Outputs; extension rule fills every bit above the 16-bit immediate
  always_comb begin
    A       = a_q;
    B       = b_q;
    DbgData = dbg_rd;
    ExtImm  = {{(WIDTH - 16){Instr[15] & ~Ori}}, Instr[15:0]};
  end

endmodule

// File: tb/tb_register_file_stage.sv
// Scoreboard bench for register_file_stage: stimulus pushes expected values,
// a monitor pops and compares them at each falling clock edge.
module tb_register_file_stage;

  localparam int unsigned W = 32;
  localparam int SelA = 0, SelB = 1, SelImm = 2, SelDbg = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  Instr;
  logic         RegWrite, RegDst, MemtoReg, Ori;
  logic [W-1:0] ALUOut, MemData;
  logic [W-1:0] A, B, ExtImm, DbgData;
  logic [4:0]   DbgAddr;

  int total = 0;
  int bad   = 0;

  string        q_name [$];
  int           q_sel  [$];
  logic [W-1:0] q_exp  [$];

  register_file_stage #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .Instr    (Instr),
    .RegWrite (RegWrite),
    .RegDst   (RegDst),
    .MemtoReg (MemtoReg),
    .Ori      (Ori),
    .ALUOut   (ALUOut),
    .MemData  (MemData),
    .A        (A),
    .B        (B),
    .ExtImm   (ExtImm),
    .DbgAddr  (DbgAddr),
    .DbgData  (DbgData)
  );

  always #5 clk = ~clk;

  // Monitor: compare every queued expectation against the DUT at the falling edge
  always @(negedge clk) begin
    string        nm;
    int           sel;
    logic [W-1:0] exp_v, act;
    while (q_name.size() > 0) begin
      nm    = q_name.pop_front();
      sel   = q_sel.pop_front();
      exp_v = q_exp.pop_front();
      case (sel)
        SelA:    act = A;
        SelB:    act = B;
        SelImm:  act = ExtImm;
        default: act = DbgData;
      endcase
      total++;
      if (act !== exp_v) begin
        bad++;
        $display("FAIL %s: got %h expected %h", nm, act, exp_v);
      end
    end
  end

  task automatic push(input string nm, input int sel, input logic [W-1:0] e);
    q_name.push_back(nm);
    q_sel.push_back(sel);
    q_exp.push_back(e);
  endtask

  // Let the monitor consume everything queued so far
  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_dbg(input string nm, input logic [4:0] addr, input logic [W-1:0] e);
    DbgAddr = addr;
    push(nm, SelDbg, e);
    sample();
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs_f, input logic [4:0] rt_f,
                                     input logic [4:0] rd_f);
    mk = {6'd0, rs_f, rt_f, rd_f, 11'd0};
  endfunction

  initial begin
    rst = 1'b1; Instr = '0; RegWrite = 1'b0; RegDst = 1'b0; MemtoReg = 1'b0; Ori = 1'b0;
    ALUOut = '0; MemData = '0; DbgAddr = '0;
    step(); step();
    rst = 1'b0;

    // Reset contents
    check_dbg("rst_r0", 5'd0, 32'h0);
    check_dbg("rst_r5", 5'd5, 32'h0);
    check_dbg("rst_r28", 5'd28, 32'h1000_8000);
    check_dbg("rst_r29", 5'd29, 32'h7FFF_EFFC);

    // Load A/B from $gp/$sp, then async reset between edges clears them at once
    Instr = mk(5'd28, 5'd29, 5'd0);
    step();
    push("ab_load_a", SelA, 32'h1000_8000);
    push("ab_load_b", SelB, 32'h7FFF_EFFC);
    sample();
    step();
    rst = 1'b1;
    push("async_rst_a", SelA, 32'h0);
    push("async_rst_b", SelB, 32'h0);
    sample();
    rst = 1'b0;
    check_dbg("post_rst_r28", 5'd28, 32'h1000_8000);

    // Write to $0 is discarded
    Instr = mk(5'd0, 5'd0, 5'd0); RegDst = 1'b1; MemtoReg = 1'b0; ALUOut = 32'hDEAD_BEEF;
    RegWrite = 1'b1;
    step();
    RegWrite = 1'b0;
    check_dbg("wr_r0", 5'd0, 32'h0);
    push("wr_r0_a", SelA, 32'h0);
    sample();

    // rt address with memory data
    Instr = mk(5'd0, 5'd9, 5'd0); RegDst = 1'b0; MemtoReg = 1'b1; MemData = 32'h1234_5678;
    RegWrite = 1'b1;
    step();
    RegWrite = 1'b0;
    check_dbg("wr_r9", 5'd9, 32'h1234_5678);

    // rd address with ALU data
    Instr = mk(5'd0, 5'd0, 5'd10); RegDst = 1'b1; MemtoReg = 1'b0; ALUOut = 32'hCAFE_0001;
    RegWrite = 1'b1;
    step();
    RegWrite = 1'b0;
    check_dbg("wr_r10", 5'd10, 32'hCAFE_0001);
    check_dbg("r9_kept", 5'd9, 32'h1234_5678);

    // Same-edge read/write: A sees old value, then new value one edge later
    Instr = mk(5'd0, 5'd8, 5'd0); RegDst = 1'b0; MemtoReg = 1'b0; ALUOut = 32'd5;
    RegWrite = 1'b1;
    step();
    Instr = mk(5'd8, 5'd8, 5'd0); ALUOut = 32'd7;
    step();
    RegWrite = 1'b0;
    push("nobypass_a_old", SelA, 32'd5);
    push("nobypass_b_old", SelB, 32'd5);
    sample();
    check_dbg("nobypass_r8", 5'd8, 32'd7);
    step();
    push("nobypass_a_new", SelA, 32'd7);
    push("nobypass_b_new", SelB, 32'd7);
    sample();

    // Immediate extension
    Instr = 32'h0000_8001; Ori = 1'b0;
    push("ext_sign_neg", SelImm, 32'hFFFF_8001);
    sample();
    Ori = 1'b1;
    push("ext_zero_neg", SelImm, 32'h0000_8001);
    sample();
    Instr = 32'h0000_7FFF; Ori = 1'b0;
    push("ext_sign_pos", SelImm, 32'h0000_7FFF);
    sample();
    Ori = 1'b1;
    push("ext_zero_pos", SelImm, 32'h0000_7FFF);
    sample();
    Ori = 1'b0;

    // Reset mid-operation with a write pending: nothing lands while rst is high
    Instr = mk(5'd0, 5'd12, 5'd0); RegDst = 1'b0; MemtoReg = 1'b0; ALUOut = 32'hAAAA_5555;
    RegWrite = 1'b1;
    step();
    RegWrite = 1'b0;
    check_dbg("wr_r12", 5'd12, 32'hAAAA_5555);
    step();
    Instr = mk(5'd12, 5'd12, 5'd0); ALUOut = 32'h1111_1111; RegWrite = 1'b1;
    rst = 1'b1;
    DbgAddr = 5'd12;
    push("midrst_a", SelA, 32'h0);
    push("midrst_b", SelB, 32'h0);
    push("midrst_r12", SelDbg, 32'h0);
    sample();
    sample();
    rst = 1'b0;
    RegWrite = 1'b0;
    check_dbg("midrst_r12_after", 5'd12, 32'h0);
    check_dbg("midrst_r29", 5'd29, 32'h7FFF_EFFC);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && q_name.size() > 0; i++) sample();
    if (q_name.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q_name.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_file_stage.md
Name: register_file_stage

Overview:
- Architectural register file plus the non-architectural A/B operand latches and immediate extender of the multicycle MIPS datapath.
- Sits directly downstream of the control unit.
- Consumes RegWrite, RegDst, MemtoReg and Ori from the control unit, and the instruction word from the instruction register.
- Feeds A, B and the extended immediate to the ALU source muxes. Takes write-back data from the ALUOut and memory-data registers.

Parameters:
- WIDTH, 32, data width of registers and buses.
- SP_INIT, 32'h7FFF_EFFC, reset value of register 29 ($sp).
- GP_INIT, 32'h1000_8000, reset value of register 28 ($gp).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous reset, active-high.
- Instr  input  32  instruction register contents; rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
- RegWrite  input  1  write enable for register array.
- RegDst  input  1  write address select: 0=rt, 1=rd.
- MemtoReg  input  1  write data select: 0=ALUOut, 1=MemData.
- Ori  input  1  immediate extension select: 0=sign-extend, 1=zero-extend.
- ALUOut  input  WIDTH  ALU result register value.
- MemData  input  WIDTH  memory data register value.
- A  output  WIDTH  latched rs operand.
- B  output  WIDTH  latched rt operand.
- ExtImm  output  WIDTH  extended immediate, combinational.
- DbgAddr  input  5  debug read address.
- DbgData  output  WIDTH  debug read data, combinational.

Behaviour:
- Array: 32 x WIDTH registers.
  - Register 0 always reads 0; writes to it are discarded.
  - No physical storage for register 0 is required.
- Reset (rst=1, asynchronous, any cycle including mid-instruction):
  - All registers clear to 0, except reg28=GP_INIT and reg29=SP_INIT.
  - A=0, B=0 immediately.
  - Reset has priority over any write on the same edge.
- Write address: WA = RegDst ? Instr[15:11] : Instr[20:16].
- Write data: WD = MemtoReg ? MemData : ALUOut.
- Write: on rising clk with RegWrite=1 and rst=0, array[WA] <= WD.
  - One write per cycle; takes effect for reads after the edge.
- Read ports (combinational): RD1 = array[rs], RD2 = array[rt], 0 when the address is 0.
- A/B latches:
  - Load RD1/RD2 on every rising clk edge; no enable.
  - Value comes from the array before that edge's write (no write-through bypass).
  - The multicycle FSM guarantees write-back and decode never need same-edge forwarding.
- Latency:
  - Register write visible on RD1/RD2 the same cycle after the edge.
  - Register write visible on A/B one edge later.
- ExtImm:
  - Ori=0: {{16{Instr[15]}}, Instr[15:0]}.
  - Ori=1: {16'h0000, Instr[15:0]}.
  - For WIDTH>32, extension fills all upper bits by the same rule.
- DbgData = array[DbgAddr], 0 for address 0. Observes the post-write state immediately after each edge.
- RegWrite=0: array unchanged regardless of RegDst/MemtoReg toggling.
- X/unknown on Instr is not required to be handled when RegWrite=0. A and B may carry X in that case.
- No output depends on an internal state machine. All sequential state is the array plus A/B.

Test Plan:
- Reset check: assert rst mid-cycle -> A=B=0 immediately. After release, DbgData at address 0, 5, 28, 29 reads 0, 0, 32'h10008000, 32'h7FFFEFFC.
- Write to $0: RegWrite=1, RegDst=1, rd=0, ALUOut=32'hDEADBEEF -> DbgData(0)=0. With rs=0, A=0 next edge.
- Write address/data select, part 1: RegDst=0, rt=9, MemtoReg=1, MemData=32'h1234_5678 -> reg9=32'h12345678.
- Write address/data select, part 2: RegDst=1, rd=10, MemtoReg=0, ALUOut=32'hCAFE0001 -> reg10=32'hCAFE0001, reg9 unchanged.
- No bypass on same-edge read/write: reg8=5; set rs=8 and write reg8=7 on the same edge -> A=5 after that edge, A=7 after the following edge.
- Immediate extension: Instr[15:0]=16'h8001 -> ExtImm=32'hFFFF8001 with Ori=0, 32'h00008001 with Ori=1. 16'h7FFF -> 32'h00007FFF for both.
- Reset mid-operation: reg12 written to 32'hAAAA5555, then rst pulsed asynchronously between edges while RegWrite=1 -> reg12=0, A/B=0, and no write lands on the edge during rst.
